// File: rtl/corelet_pkg.sv
// corelet_pkg: shared FSM state encoding, inst bus bit positions and
// inst_w opcodes for the corelet instruction sequencer.
package corelet_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        W_FILL  = 3'd1,
        K_LOAD  = 3'd2,
        K_FLUSH = 3'd3,
        X_FILL  = 3'd4,
        EXEC    = 3'd5,
        DRAIN   = 3'd6,
        DONE    = 3'd7
    } state_e;

    // Bit positions on the 7-bit inst bus.
    localparam int OFIFO_RD = 6;
    localparam int IFIFO_WR = 5;
    localparam int IFIFO_RD = 4;
    localparam int L0_RD    = 3;
    localparam int L0_WR    = 2;

    // inst_w[1:0] opcodes.
    localparam logic [1:0] INSTW_IDLE  = 2'd0;
    localparam logic [1:0] INSTW_KLOAD = 2'd1;
    localparam logic [1:0] INSTW_EXEC  = 2'd2;

endpackage

// File: rtl/corelet_ctrl_sram_fill_gen.sv
// sram_fill_gen: issues count consecutive SRAM reads starting at base after
// a go pulse. wr is the read-issue qualifier delayed by one cycle, matching
// the one-cycle SRAM read latency, so it marks when data reaches L0.
// last is high in the cycle of the final wr strobe.
module sram_fill_gen #(
    parameter int addr_bw = 11,
    parameter int cnt_bw  = 7
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               go,
    input  logic [addr_bw-1:0] base,
    input  logic [cnt_bw-1:0]  count,
    output logic               cen,
    output logic [addr_bw-1:0] addr,
    output logic               wr,
    output logic               last
);

    logic               cen_q,   cen_d;
    logic [addr_bw-1:0] addr_q,  addr_d;
    logic               wr_q,    wr_d;
    logic [cnt_bw-1:0]  idx_q,   idx_d;
    logic [addr_bw-1:0] base_q,  base_d;
    logic [cnt_bw-1:0]  count_q, count_d;

    // Next read address/enable; go restarts the sequence at base.
    always_comb begin
        cen_d   = 1'b1;
        addr_d  = addr_q;
        idx_d   = idx_q;
        base_d  = base_q;
        count_d = count_q;
        wr_d    = ~cen_q;
        if (go) begin
            cen_d   = 1'b0;
            addr_d  = base;
            idx_d   = cnt_bw'(1);
            base_d  = base;
            count_d = count;
        end else if (idx_q < count_q) begin
            cen_d  = 1'b0;
            addr_d = base_q + addr_bw'(idx_q);
            idx_d  = idx_q + cnt_bw'(1);
        end else begin
            cen_d = 1'b1;
        end
    end

    // Address generator state registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cen_q   <= 1'b1;
            addr_q  <= '0;
            wr_q    <= 1'b0;
            idx_q   <= '0;
            base_q  <= '0;
            count_q <= '0;
        end else begin
            cen_q   <= cen_d;
            addr_q  <= addr_d;
            wr_q    <= wr_d;
            idx_q   <= idx_d;
            base_q  <= base_d;
            count_q <= count_d;
        end
    end

    assign cen  = cen_q;
    assign addr = addr_q;
    assign wr   = wr_q;
    assign last = wr_q & cen_q;

endmodule

// File: rtl/corelet_ctrl.sv
// corelet_ctrl: per-tile instruction sequencer for the corelet.
// Kernel fill -> kernel load -> flush -> activation fill -> execute -> drain.
// Optional macro CTRL_PERF_EN adds cycle_cnt/stall_cnt performance counters.
module corelet_ctrl
    import corelet_pkg::*;
#(
    parameter int row      = 8,
    parameter int col      = 8,
    parameter int addr_bw  = 11,
    parameter int len_bw   = 7,
    parameter int L0_DEPTH = 64,
    parameter int W_BASE   = 0,
    parameter int X_BASE   = 64
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [len_bw-1:0]  len,
    input  logic               ofifo_valid,
    output logic [6:0]         inst,
    output logic               xmem_cen,
    output logic [addr_bw-1:0] xmem_addr,
    output logic               psum_wr,
    output logic [addr_bw-1:0] psum_addr,
    output logic               busy,
    output logic               done,
    output logic               err
`ifdef CTRL_PERF_EN
    ,
    output logic [31:0]        cycle_cnt,
    output logic [15:0]        stall_cnt
`endif
);

    localparam int CNT_MAX = (L0_DEPTH > row + col) ? L0_DEPTH : (row + col);
    localparam int CNT_BW  = $clog2(CNT_MAX + 1);
    localparam logic [len_bw:0] L0_DEPTH_V = (len_bw + 1)'(L0_DEPTH);

    state_e             state_q,     state_d;
    logic [CNT_BW-1:0]  cnt_q,       cnt_d;
    logic [len_bw-1:0]  len_q,       len_d;
    logic [len_bw-1:0]  rd_cnt_q,    rd_cnt_d;
    logic [addr_bw-1:0] ptr_q,       ptr_d;
    logic [addr_bw-1:0] psum_addr_q, psum_addr_d;
    logic               psum_wr_q,   psum_wr_d;
    logic               ofifo_rd_q,  ofifo_rd_d;
    logic               l0_rd_q,     l0_rd_d;
    logic [1:0]         inst_w_q,    inst_w_d;
    logic               busy_q,      busy_d;
    logic               done_q,      done_d;
    logic               err_q,       err_d;

    logic               len_ok_s;
    logic               accept_s;
    logic               rd_take_s;
    logic               fill_go_s;
    logic [addr_bw-1:0] fill_base_s;
    logic [len_bw-1:0]  fill_cnt_s;
    logic               fill_cen_s;
    logic [addr_bw-1:0] fill_addr_s;
    logic               fill_wr_s;
    logic               fill_last_s;
    logic [CNT_BW-1:0]  len_m1_s;

    // One address generator serves both the kernel and activation fills.
    sram_fill_gen #(
        .addr_bw (addr_bw),
        .cnt_bw  (len_bw)
    ) u_fill (
        .clk   (clk),
        .reset (reset),
        .go    (fill_go_s),
        .base  (fill_base_s),
        .count (fill_cnt_s),
        .cen   (fill_cen_s),
        .addr  (fill_addr_s),
        .wr    (fill_wr_s),
        .last  (fill_last_s)
    );

    // Sequencer next state, OFIFO read decision and next registered outputs.
    always_comb begin
        len_ok_s    = (len != {len_bw{1'b0}}) && ({1'b0, len} <= L0_DEPTH_V);
        accept_s    = (state_q == IDLE) && start && len_ok_s;
        len_m1_s    = CNT_BW'(len_q) - CNT_BW'(1);
        state_d     = state_q;
        cnt_d       = cnt_q;
        len_d       = len_q;
        err_d       = 1'b0;
        fill_go_s   = 1'b0;
        fill_base_s = addr_bw'(W_BASE);
        fill_cnt_s  = len_bw'(col);

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (len_ok_s) begin
                        state_d   = W_FILL;
                        len_d     = len;
                        cnt_d     = '0;
                        fill_go_s = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            W_FILL: begin
                if (fill_last_s) begin
                    state_d = K_LOAD;
                    cnt_d   = '0;
                end else begin
                    state_d = W_FILL;
                end
            end
            K_LOAD: begin
                if (cnt_q == CNT_BW'(col - 1)) begin
                    state_d = K_FLUSH;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_BW'(1);
                end
            end
            K_FLUSH: begin
                // Kernel words need row+col cycles to settle across the array.
                if (cnt_q == CNT_BW'(row + col - 1)) begin
                    state_d     = X_FILL;
                    cnt_d       = '0;
                    fill_go_s   = 1'b1;
                    fill_base_s = addr_bw'(X_BASE);
                    fill_cnt_s  = len_q;
                end else begin
                    cnt_d = cnt_q + CNT_BW'(1);
                end
            end
            X_FILL: begin
                if (fill_last_s) begin
                    state_d = EXEC;
                    cnt_d   = '0;
                end else begin
                    state_d = X_FILL;
                end
            end
            EXEC: begin
                if (cnt_q == len_m1_s) begin
                    state_d = DRAIN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_BW'(1);
                end
            end
            DRAIN: begin
                if (rd_cnt_q == len_q) begin
                    state_d = DONE;
                end else begin
                    state_d = DRAIN;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        // Rows are pulled from the OFIFO while executing or draining.
        rd_take_s = ((state_q == EXEC) || (state_q == DRAIN)) &&
                    ofifo_valid && (rd_cnt_q < len_q);

        if (accept_s) begin
            rd_cnt_d = '0;
        end else if (rd_take_s) begin
            rd_cnt_d = rd_cnt_q + len_bw'(1);
        end else begin
            rd_cnt_d = rd_cnt_q;
        end

        if (rd_take_s) begin
            psum_addr_d = ptr_q;
            ptr_d       = ptr_q + addr_bw'(1);
        end else begin
            psum_addr_d = psum_addr_q;
            ptr_d       = ptr_q;
        end
        psum_wr_d  = rd_take_s;
        ofifo_rd_d = rd_take_s;

        l0_rd_d = (state_d == K_LOAD) || (state_d == EXEC);
        case (state_d)
            K_LOAD:  inst_w_d = INSTW_KLOAD;
            EXEC:    inst_w_d = INSTW_EXEC;
            default: inst_w_d = INSTW_IDLE;
        endcase
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    // Sequencer state and registered output flops.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            len_q       <= '0;
            rd_cnt_q    <= '0;
            ptr_q       <= '0;
            psum_addr_q <= '0;
            psum_wr_q   <= 1'b0;
            ofifo_rd_q  <= 1'b0;
            l0_rd_q     <= 1'b0;
            inst_w_q    <= INSTW_IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            len_q       <= len_d;
            rd_cnt_q    <= rd_cnt_d;
            ptr_q       <= ptr_d;
            psum_addr_q <= psum_addr_d;
            psum_wr_q   <= psum_wr_d;
            ofifo_rd_q  <= ofifo_rd_d;
            l0_rd_q     <= l0_rd_d;
            inst_w_q    <= inst_w_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    // Pack the inst bus; the ififo bits are unused by this sequencer.
    always_comb begin
        inst           = 7'd0;
        inst[OFIFO_RD] = ofifo_rd_q;
        inst[IFIFO_WR] = 1'b0;
        inst[IFIFO_RD] = 1'b0;
        inst[L0_RD]    = l0_rd_q;
        inst[L0_WR]    = fill_wr_s;
        inst[1:0]      = inst_w_q;
    end

    assign xmem_cen  = fill_cen_s;
    assign xmem_addr = fill_addr_s;
    assign psum_wr   = psum_wr_q;
    assign psum_addr = psum_addr_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;

`ifdef CTRL_PERF_EN
    logic [31:0] cycle_cnt_q, cycle_cnt_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;

    // Per-tile busy-cycle and drain-stall counters, cleared on accepted start.
    always_comb begin
        cycle_cnt_d = cycle_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (accept_s) begin
            cycle_cnt_d = 32'd0;
            stall_cnt_d = 16'd0;
        end else begin
            if (busy_q) begin
                cycle_cnt_d = cycle_cnt_q + 32'd1;
            end else begin
                cycle_cnt_d = cycle_cnt_q;
            end
            if ((state_q == DRAIN) && !ofifo_valid) begin
                stall_cnt_d = stall_cnt_q + 16'd1;
            end else begin
                stall_cnt_d = stall_cnt_q;
            end
        end
    end

    // Performance counter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cycle_cnt_q <= 32'd0;
            stall_cnt_q <= 16'd0;
        end else begin
            cycle_cnt_q <= cycle_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign cycle_cnt = cycle_cnt_q;
    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_corelet_ctrl.sv
// tb_corelet_ctrl: randomized self-checking bench. The reference model
// describes a tile as a fixed timeline of phases measured in cycles since the
// first fill cycle, plus a count of OFIFO reads taken.
module tb_corelet_ctrl;

    localparam int ROW   = 8;
    localparam int COL   = 8;
    localparam int ABW   = 11;
    localparam int LBW   = 7;
    localparam int DEPTH = 64;
    localparam int WB    = 0;
    localparam int XB    = 64;
    localparam int SX    = 3 * COL + ROW + 1;   // first activation-fill cycle
    localparam int NEVER = 1 << 30;

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic           start = 1'b0;
    logic [LBW-1:0] len = '0;
    logic           ofifo_valid = 1'b0;
    logic [6:0]     inst;
    logic           xmem_cen;
    logic [ABW-1:0] xmem_addr;
    logic           psum_wr;
    logic [ABW-1:0] psum_addr;
    logic           busy;
    logic           done;
    logic           err;
`ifdef CTRL_PERF_EN
    logic [31:0]    cycle_cnt;
    logic [15:0]    stall_cnt;
`endif

    corelet_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .len         (len),
        .ofifo_valid (ofifo_valid),
        .inst        (inst),
        .xmem_cen    (xmem_cen),
        .xmem_addr   (xmem_addr),
        .psum_wr     (psum_wr),
        .psum_addr   (psum_addr),
        .busy        (busy),
        .done        (done),
        .err         (err)
`ifdef CTRL_PERF_EN
        ,
        .cycle_cnt   (cycle_cnt),
        .stall_cnt   (stall_cnt)
`endif
    );

    initial begin
        forever #5 clk = ~clk;
    end

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state (describes the current cycle).
    bit m_in = 0;
    int m_k = 0;
    int m_len = 0;
    int m_done_k = NEVER;
    int m_reads = 0;
    int m_ptr = 0;
    int m_paddr = 0;
    int m_cyc = 0;
    int m_stall = 0;
    bit m_rd = 0;
    bit m_err = 0;
    int vmode = 1;

    // Observed tallies from the DUT.
    int obs_done = 0;
    int obs_wr = 0;
    int obs_err = 0;
    int obs_busy = 0;
    int obs_cen = 0;
    int obs_last_paddr = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_in = 0; m_k = 0; m_len = 0; m_done_k = NEVER; m_reads = 0;
        m_ptr = 0; m_paddr = 0; m_cyc = 0; m_stall = 0; m_rd = 0; m_err = 0;
    endtask

    // Advance the model across one clock edge using the inputs of the cycle just ending.
    task automatic model_step();
        int e;
        bit in_drain;
        if (!reset) begin
            model_reset();
        end else begin
            m_rd = 0;
            m_err = 0;
            if (m_in) begin
                m_cyc++;
                if (m_k == m_done_k) begin
                    m_in = 0;
                end else begin
                    e = SX + m_len + 1;
                    if (m_k >= e) begin
                        in_drain = (m_k >= e + m_len);
                        if (in_drain && !ofifo_valid) m_stall++;
                        if (in_drain && m_reads == m_len) begin
                            m_done_k = m_k + 1;
                        end else if (ofifo_valid && m_reads < m_len) begin
                            m_rd = 1;
                            m_reads++;
                            m_paddr = m_ptr;
                            m_ptr = (m_ptr + 1) % (1 << ABW);
                        end
                    end
                    m_k++;
                end
            end else if (start) begin
                if (len == 0 || int'(len) > DEPTH) begin
                    m_err = 1;
                end else begin
                    m_in = 1; m_k = 0; m_len = int'(len); m_reads = 0;
                    m_done_k = NEVER; m_cyc = 0; m_stall = 0;
                end
            end
        end
    endtask

    function automatic logic [6:0] exp_inst();
        bit wr, rd;
        logic [1:0] w;
        int e;
        e  = SX + m_len + 1;
        wr = m_in && ((m_k >= 1 && m_k <= COL) || (m_k >= SX + 1 && m_k <= SX + m_len));
        rd = 0;
        w  = 2'b00;
        if (m_in && m_k >= COL + 1 && m_k <= 2 * COL) begin rd = 1; w = 2'b01; end
        if (m_in && m_k >= e && m_k < e + m_len) begin rd = 1; w = 2'b10; end
        return {m_rd, 1'b0, 1'b0, rd, wr, w};
    endfunction

    task automatic compare_cycle();
        bit ecen;
        int eaddr;
        ecen  = !(m_in && (m_k < COL || (m_k >= SX && m_k < SX + m_len)));
        eaddr = (m_k < COL) ? WB + m_k : XB + m_k - SX;
        chk("inst", 32'(inst), 32'(exp_inst()));
        chk("xmem_cen", 32'(xmem_cen), 32'(ecen));
        if (!ecen) chk("xmem_addr", 32'(xmem_addr), eaddr);
        chk("psum_wr", 32'(psum_wr), 32'(m_rd));
        chk("psum_addr", 32'(psum_addr), m_paddr);
        chk("busy", 32'(busy), 32'(m_in));
        chk("done", 32'(done), 32'(m_in && m_k == m_done_k));
        chk("err", 32'(err), 32'(m_err));
`ifdef CTRL_PERF_EN
        chk("cycle_cnt", cycle_cnt, m_cyc);
        chk("stall_cnt", 32'(stall_cnt), m_stall);
`endif
        if (done) obs_done++;
        if (psum_wr) begin obs_wr++; obs_last_paddr = int'(psum_addr); end
        if (err) obs_err++;
        if (busy) obs_busy++;
        if (!xmem_cen) obs_cen++;
    endtask

    task automatic clear_tallies();
        obs_done = 0; obs_wr = 0; obs_err = 0; obs_busy = 0; obs_cen = 0;
    endtask

    // Model advances at each rising edge.
    initial begin
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    // Asynchronous reset clears the model at once.
    initial begin
        forever begin
            @(negedge reset);
            model_reset();
        end
    end

    // Outputs are compared on every falling edge.
    initial begin
        forever begin
            @(negedge clk);
            compare_cycle();
        end
    end

    // ofifo_valid driver.
    initial begin
        int e;
        forever begin
            @(negedge clk);
            e = SX + m_len + 1;
            case (vmode)
                0:       ofifo_valid = m_in && m_k >= e + 2;
                1:       ofifo_valid = ($urandom_range(0, 3) != 0);
                2:       ofifo_valid = m_in && m_k >= e + m_len && ((m_k - (e + m_len)) % 3 == 0);
                default: ofifo_valid = 1'b1;
            endcase
        end
    end

    // Called at a falling edge; returns at the first idle falling edge after the tile.
    task automatic run_tile(input int l, input int inj_k);
        int  guard;
        bit  seen;
        start = 1'b1;
        len   = LBW'(l);
        @(negedge clk);
        start = 1'b0;
        guard = 0;
        seen  = 0;
        while (guard < 3000) begin
            if (busy) seen = 1;
            else if (seen) break;
            start = (inj_k >= 0) && m_in && (m_k == inj_k);
            if (start) len = '0;
            @(negedge clk);
            guard++;
        end
        start = 1'b0;
        n_tests++;
        if (!(seen && !busy)) begin
            n_fail++;
            $display("FAIL tile_timeout: busy=%0b seen=%0b required tile end within 3000 cycles", busy, seen);
        end
    endtask

    task automatic issue_bad(input logic [LBW-1:0] l);
        start = 1'b1;
        len   = l;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int l;
        model_reset();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_inst", 32'(inst), 32'd0);
        chk("rst_cen", 32'(xmem_cen), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);

        // Nominal tile, valid from the third execute cycle.
        clear_tallies();
        vmode = 0;
        run_tile(8, -1);
        chk("t1_wr_cnt", obs_wr, 32'd8);
        chk("t1_done_cnt", obs_done, 32'd1);
        chk("t1_busy_cycles", obs_busy, 32'd54);
        chk("t1_last_paddr", obs_last_paddr, 32'd7);
        chk("t1_cen_cycles", obs_cen, 32'd16);
`ifdef CTRL_PERF_EN
        chk("t1_cycle_cnt", cycle_cnt, 32'd54);
`endif

        // Illegal starts.
        clear_tallies();
        issue_bad(7'd0);
        issue_bad(7'd65);
        chk("t2_err_cnt", obs_err, 32'd2);
        chk("t2_busy", obs_busy, 32'd0);
        chk("t2_no_sram", obs_cen, 32'd0);

        // Drain with valid pattern 1,0,0.
        clear_tallies();
        vmode = 2;
        run_tile(8, -1);
        chk("t4_wr_cnt", obs_wr, 32'd8);
        chk("t4_done_cnt", obs_done, 32'd1);
        chk("t4_busy_cycles", obs_busy, 32'd74);
`ifdef CTRL_PERF_EN
        chk("t4_stall_cnt", 32'(stall_cnt), 32'd15);
`endif

        // Start during execute must be ignored.
        clear_tallies();
        vmode = 3;
        run_tile(8, SX + 9 + 2);
        repeat (3) @(negedge clk);
        chk("t3_done_cnt", obs_done, 32'd1);
        chk("t3_err_cnt", obs_err, 32'd0);
        chk("t3_wr_cnt", obs_wr, 32'd8);
        chk("t3_idle", 32'(busy), 32'd0);

        // Asynchronous reset in the middle of execute.
        vmode = 1;
        start = 1'b1;
        len   = 7'd8;
        @(negedge clk);
        start = 1'b0;
        for (int g = 0; g < 200; g++) begin
            if (m_in && m_k == SX + 9 + 3) break;
            @(negedge clk);
        end
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        chk("t5_inst", 32'(inst), 32'd0);
        chk("t5_cen", 32'(xmem_cen), 32'd1);
        chk("t5_addr", 32'(xmem_addr), 32'd0);
        chk("t5_psum_wr", 32'(psum_wr), 32'd0);
        chk("t5_psum_addr", 32'(psum_addr), 32'd0);
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_done", 32'(done), 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;

        // Back-to-back tiles, psum address continues.
        clear_tallies();
        run_tile(4, -1);
        clear_tallies();
        run_tile(4, -1);
        chk("t6_wr_cnt", obs_wr, 32'd4);
        chk("t6_last_paddr", obs_last_paddr, 32'd7);
        chk("t6_done_cnt", obs_done, 32'd1);
`ifdef CTRL_PERF_EN
        chk("t6_cycle_cnt", cycle_cnt, obs_busy);
`endif

        // Randomized tiles including length boundaries.
        for (int i = 0; i < 16; i++) begin
            vmode = 1;
            if ($urandom_range(0, 3) == 0) issue_bad(LBW'($urandom_range(65, 127)));
            l = (i == 0) ? 64 : (i == 1) ? 1 : int'($urandom_range(1, 64));
            run_tile(l, ($urandom_range(0, 1) == 1) ? SX + l + 1 + int'($urandom_range(0, l - 1)) : -1);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/corelet_ctrl.md
Name: corelet_ctrl

Overview:
Instruction sequencer that drives the corelet's 7-bit inst bus and the activation/weight SRAM read port. For each tile it:
- fills L0 with col kernel words and loads them into the MAC array;
- fills L0 with len activation vectors and executes them;
- drains the OFIFO into psum SRAM.

It is the initiator to the corelet, which only responds to inst and reports o_valid.

Parameters:
row, 8, MAC array rows (kernel flush timing)
col, 8, MAC array columns = kernel words per tile
addr_bw, 11, SRAM address width
len_bw, 7, width of activation count
L0_DEPTH, 64, L0 FIFO depth; max legal len and col
W_BASE, 0, weight SRAM base address
X_BASE, 64, activation SRAM base address

Ports:
clk  input  1  clock
reset  input  1  asynchronous active-low reset
start  input  1  one-cycle request to run a tile; sampled only in IDLE
len  input  len_bw  activation vectors in tile, sampled with start
ofifo_valid  input  1  corelet o_valid: OFIFO holds a full row
inst  output  7  {ofifo_rd, ififo_wr, ififo_rd, l0_rd, l0_wr, inst_w[1:0]}
xmem_cen  output  1  active-low SRAM read enable
xmem_addr  output  addr_bw  SRAM read address
psum_wr  output  1  psum SRAM write strobe
psum_addr  output  addr_bw  psum SRAM write address
busy  output  1  high from accepted start until DONE
done  output  1  one-cycle pulse at tile end
err  output  1  one-cycle pulse when start is rejected

Behaviour:
- Reset (reset=0, async): state IDLE; inst=0, xmem_cen=1, xmem_addr=0, psum_wr=0, psum_addr=0, busy=0, done=0, err=0; all counters 0. Reset mid-tile aborts immediately and discards progress.
- All outputs are registered.
- inst[5] and inst[4] (ififo) are tied 0.
- inst_w encoding: 01 = kernel load, 10 = execute, 00 = idle.
- SRAM read latency is 1 cycle: address at cycle t means data is at the corelet input at t+1.
  - l0_wr is therefore a 1-cycle-delayed copy of the read-issue qualifier.
- Start acceptance:
  - start with len==0 or len>L0_DEPTH: err pulse, stay IDLE.
  - Otherwise latch len, busy=1, go to W_FILL.
  - start while busy is ignored (no err).
- W_FILL: xmem_cen=0, addresses W_BASE..W_BASE+col-1 over col cycles; l0_wr lags by one cycle. After the last l0_wr (col+1 cycles total) go to K_LOAD.
- K_LOAD: l0_rd=1, inst_w=01 for exactly col cycles, then go to K_FLUSH.
- K_FLUSH: inst=0 for row+col cycles (kernel propagation), then go to X_FILL.
- X_FILL: same as W_FILL with addresses X_BASE..X_BASE+len-1; len+1 cycles, then go to EXEC.
- EXEC: l0_rd=1, inst_w=10 for exactly len cycles, then go to DRAIN.
- OFIFO reads (EXEC and DRAIN):
  - Whenever ofifo_valid=1 and rd_cnt<len: assert ofifo_rd and psum_wr in the same cycle, increment psum_addr and rd_cnt.
  - psum_addr is not reset between tiles (it accumulates); it wraps modulo 2^addr_bw.
- DRAIN: stays indefinitely until rd_cnt==len (no timeout); gaps in ofifo_valid simply stall. Then go to DONE.
- DONE: done=1 for one cycle, busy=0 in the next cycle, then IDLE. start in the DONE cycle is ignored.
- L0 is never overfilled: legality check at start guarantees fill length ≤ L0_DEPTH. l0_full/l0_ready are not monitored.
- Counters are sized for L0_DEPTH and row+col.

Optional Feature:
Macro: CTRL_PERF_EN.
- Defined: adds output cycle_cnt [31:0].
  - Cleared on accepted start, incremented every busy cycle, holds after DONE.
  - Also counts drain stall cycles into stall_cnt [15:0] (cycles in DRAIN with ofifo_valid=0).
  - Both reset to 0.
- Undefined: neither port nor counters exist; behaviour is otherwise identical.

Decomposition:
- Shared package corelet_pkg holds:
  - state enum: IDLE, W_FILL, K_LOAD, K_FLUSH, X_FILL, EXEC, DRAIN, DONE;
  - inst bit-index constants (OFIFO_RD=6, IFIFO_WR=5, IFIFO_RD=4, L0_RD=3, L0_WR=2);
  - inst_w codes (INSTW_IDLE=0, INSTW_KLOAD=1, INSTW_EXEC=2).
- One natural sub-module, sram_fill_gen: base/count address generator with 1-cycle delayed write strobe. It is instantiated once and reused for W_FILL and X_FILL.

Test Plan:
1. Nominal tile, col=8, len=8, ofifo_valid high from EXEC cycle 3:
   - xmem_addr 0..7 then 64..71; l0_wr lags cen by 1 cycle;
   - K_LOAD inst_w=01 for 8 cycles; K_FLUSH idle for 16 cycles; EXEC inst_w=10 for 8 cycles;
   - exactly 8 psum_wr with psum_addr 0..7; one done pulse.
2. Illegal start, len=0 and len=65: err pulse each time, busy stays 0, no SRAM activity.
3. start pulsed during EXEC of a running tile: ignored; single done; second tile runs only after a later start.
4. ofifo_valid toggles 1,0,0,1... in DRAIN: ofifo_rd only when valid; done after the 8th read; with CTRL_PERF_EN, stall_cnt equals the number of low DRAIN cycles.
5. reset driven low mid-EXEC, async between clock edges: outputs return to reset values without waiting for an edge; next start runs a full tile from W_FILL.
6. Back-to-back tiles with len=4: second tile's psum_addr continues at 4..7; cycle_cnt equals that tile's busy-cycle count.
